period_readout_serializer: RTL
==============================

Name: period_readout_serializer

Overview:
Downstream consumer of the per-pixel frequency_counter PERIOD outputs. On a START pulse it snapshots the packed PERIOD bus for one image line. It then streams the snapshot out one pixel word per transfer over a valid/ready interface, for off-chip readout or logging. It decouples the live counters, which keep updating, from a slow or stalling reader.

Parameters:
NUM_PIXELS, 16, number of pixel PERIOD words per line; legal range is 2 or more.
COUNTER_BITS, 15, width of each PERIOD word; must match frequency_counter COUNTER_BITS.
INDEX_BITS (localparam), $clog2(NUM_PIXELS+1), width of OUT_INDEX.

Ports:
CLK  input  1  single clock for the whole block.
RST_N  input  1  asynchronous, active-low reset.
START  input  1  one-cycle request to snapshot PERIOD_IN and begin streaming.
PERIOD_IN  input  NUM_PIXELS*COUNTER_BITS  packed PERIODs; pixel i occupies [i*COUNTER_BITS +: COUNTER_BITS].
OUT_DATA  output  COUNTER_BITS  current word.
OUT_INDEX  output  INDEX_BITS  pixel index of current word.
OUT_VALID  output  1  OUT_DATA/OUT_INDEX/OUT_LAST valid.
OUT_READY  input  1  consumer accepts the word this cycle.
OUT_LAST  output  1  high with the final word of the frame.
BUSY  output  1  a frame is being captured or streamed.
FRAME_DONE  output  1  one-cycle pulse after the final transfer.
OVERRUN  output  1  sticky flag: a START was dropped.

Behaviour:
- Reset (asynchronous, RST_N low): state=IDLE. All outputs 0. Snapshot registers 0. Index 0.
- States:
  - IDLE -> SEND on START=1. On that same edge, PERIOD_IN is captured into the snapshot and index is cleared to 0.
  - SEND -> DONE on the transfer of the final word.
  - DONE -> IDLE unconditionally after one cycle.
- Latency: START high at edge N gives OUT_VALID=1 from edge N+1, carrying pixel 0 (bits [COUNTER_BITS-1:0]).
- Transfer: occurs on an edge where OUT_VALID and OUT_READY are both 1.
  - After a transfer, the index increments and the next word appears on the following cycle. There are no bubbles while OUT_READY is held high.
- Stall: while OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_INDEX and OUT_LAST hold constant. OUT_VALID never drops before its word is transferred.
- OUT_READY is ignored when OUT_VALID=0. OUT_VALID does not depend combinationally on OUT_READY.
- OUT_DATA and OUT_INDEX are registered or mux-from-register. PERIOD_IN changes after capture never affect the output.
- OUT_LAST=1 only with the final word: index NUM_PIXELS-1, or the checksum word when the optional feature is enabled.
- After the final transfer: OUT_VALID=0. In DONE, FRAME_DONE=1 for exactly one cycle. Then return to IDLE.
- BUSY: 1 in SEND and DONE, 0 in IDLE. BUSY rises on the edge START is accepted.
- START while BUSY=1 (including the final-transfer cycle and the DONE cycle):
  - Ignored; the snapshot and stream are unaffected.
  - OVERRUN is set to 1.
- OVERRUN clears only when a START is accepted in IDLE, or on reset.
- Minimum frame length: NUM_PIXELS+2 cycles from START to IDLE with OUT_READY held high.
- Reset asserted mid-frame: the stream aborts immediately, with no FRAME_DONE and no OUT_LAST.

Optional Feature:
READOUT_CHECKSUM_EN
- Defined: after pixel NUM_PIXELS-1, one extra word is emitted. Its value is the XOR of all NUM_PIXELS captured words, with OUT_INDEX=NUM_PIXELS and OUT_LAST=1 on this word only. The final pixel word then has OUT_LAST=0. The frame grows by one transfer. The checksum is accumulated during capture or streaming, never from the live PERIOD_IN.
- Undefined: no checksum word. OUT_INDEX never exceeds NUM_PIXELS-1. No checksum logic is synthesized.

Test Plan:
All scenarios use NUM_PIXELS=4 and COUNTER_BITS=15, with macro off unless stated.
1. Reset: RST_N=0 mid-simulation, asynchronously between edges -> OUT_VALID, BUSY, FRAME_DONE, OVERRUN, OUT_LAST all 0 immediately.
2. Basic frame: PERIOD_IN = {0x0004,0x0003,0x0002,0x0001}, START 1 cycle, OUT_READY=1.
   - OUT_DATA 0x0001,0x0002,0x0003,0x0004 on consecutive cycles, starting 1 cycle after START.
   - OUT_INDEX 0..3; OUT_LAST only at index 3.
   - FRAME_DONE pulses once; BUSY high for 5 cycles.
3. Backpressure: same data, OUT_READY toggled 1,0,0,1,0,1,1 -> each word held stable while stalled; no word lost or duplicated; order 1,2,3,4.
4. Capture isolation: change PERIOD_IN to all 0x7FFF one cycle after START -> output is still 1,2,3,4.
5. Overrun: START again at index 1 and again in the DONE cycle -> stream unchanged; OVERRUN=1. Next START in IDLE -> OVERRUN=0 and a new frame begins.
6. Checksum (READOUT_CHECKSUM_EN defined), data 1,2,3,4 -> fifth word 0x0004 (1^2^3^4) with OUT_INDEX=4 and OUT_LAST=1; word 4 has OUT_LAST=0.

Source files
------------

// File: rtl/period_readout_serializer.sv
// period_readout_serializer
// Snapshots one line of per-pixel PERIOD words on START and streams them out
// one word per valid/ready transfer, so the live counters can keep running
// while a slow reader drains the captured line.
//
// Optional feature: define READOUT_CHECKSUM_EN to append one extra word
// holding the XOR of all captured pixel words (OUT_INDEX = NUM_PIXELS).
//
// Handshake: a word moves on a rising edge where OUT_VALID and OUT_READY are
// both 1; OUT_VALID is a pure function of state (never of OUT_READY), and once
// raised it stays high with OUT_DATA/OUT_INDEX/OUT_LAST frozen until that word
// moves.
module period_readout_serializer #(
    parameter int NUM_PIXELS   = 16,
    parameter int COUNTER_BITS = 15,
    localparam int INDEX_BITS  = $clog2(NUM_PIXELS + 1)
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               START,
    input  logic [NUM_PIXELS*COUNTER_BITS-1:0] PERIOD_IN,
    output logic [COUNTER_BITS-1:0]            OUT_DATA,
    output logic [INDEX_BITS-1:0]              OUT_INDEX,
    output logic                               OUT_VALID,
    input  logic                               OUT_READY,
    output logic                               OUT_LAST,
    output logic                               BUSY,
    output logic                               FRAME_DONE,
    output logic                               OVERRUN
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

`ifdef READOUT_CHECKSUM_EN
    // The checksum word is the last one in the frame.
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(NUM_PIXELS);
`else
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(NUM_PIXELS - 1);
`endif

    state_t                             state_q, state_d;
    logic [NUM_PIXELS*COUNTER_BITS-1:0] snap_q, snap_d;
    logic [INDEX_BITS-1:0]              idx_q, idx_d;
    logic                               overrun_q, overrun_d;
    logic [COUNTER_BITS-1:0]            word_sel;
    logic                               is_last;

`ifdef READOUT_CHECKSUM_EN
    logic [COUNTER_BITS-1:0]            csum_q, csum_d;
    logic [COUNTER_BITS-1:0]            csum_in;

    // XOR of the incoming line, latched together with the snapshot so it is
    // always consistent with the captured words, never with the live bus.
    always_comb begin
        csum_in = '0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            csum_in = csum_in ^ PERIOD_IN[i*COUNTER_BITS +: COUNTER_BITS];
        end
    end
`endif

    assign is_last = (idx_q == LAST_IDX);

    // Next-state, capture, index advance and overrun bookkeeping.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
`ifdef READOUT_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d   = S_SEND;
                    snap_d    = PERIOD_IN;
                    idx_d     = '0;
                    overrun_d = 1'b0;
`ifdef READOUT_CHECKSUM_EN
                    csum_d    = csum_in;
`endif
                end
            end
            S_SEND: begin
                if (OUT_READY) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + INDEX_BITS'(1);
                    end
                end
                // A START while busy is dropped; only the flag records it.
                if (START) begin
                    overrun_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (START) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, snapshot and flag registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
`ifdef READOUT_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // Select the current word from the snapshot (or the checksum slot).
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            if (idx_q == INDEX_BITS'(i)) begin
                word_sel = snap_q[i*COUNTER_BITS +: COUNTER_BITS];
            end
        end
`ifdef READOUT_CHECKSUM_EN
        if (idx_q == INDEX_BITS'(NUM_PIXELS)) begin
            word_sel = csum_q;
        end
`endif
    end

    // Outputs decode from registers only; data is forced to 0 when not valid.
    always_comb begin
        OUT_VALID  = (state_q == S_SEND);
        OUT_DATA   = OUT_VALID ? word_sel : '0;
        OUT_INDEX  = OUT_VALID ? idx_q : '0;
        OUT_LAST   = OUT_VALID && is_last;
        BUSY       = (state_q != S_IDLE);
        FRAME_DONE = (state_q == S_DONE);
        OVERRUN    = overrun_q;
    end

endmodule
